// File: rtl/tenthirty_engine.sv
// Ten-and-a-half game engine: turn FSM, half-point scoring, bust/card-limit detection, round sequencing.
// Optional build macro AUTO_DEALER_EN: dealer draws on its own below DEALER_STAND instead of following buttons.
module tenthirty_engine #(
  parameter int unsigned MAX_CARDS    = 5,
  parameter int unsigned ROUNDS       = 4,
  parameter int unsigned LIMIT_HALF   = 21,
  parameter int unsigned DEALER_STAND = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   btn_hit,
  input  logic                   btn_stand,
  output logic                   card_req,
  input  logic                   card_vld,
  input  logic [3:0]             card_num,
  output logic [4*MAX_CARDS-1:0] hand_cards,
  output logic [3:0]             hand_cnt,
  output logic [6:0]             player_tot,
  output logic [6:0]             dealer_tot,
  output logic                   turn,
  output logic [2:0]             round_no,
  output logic [2:0]             state,
  output logic [2:0]             led
);

  localparam logic [6:0] LIMIT      = 7'(LIMIT_HALF);
  localparam logic [3:0] MAXC       = 4'(MAX_CARDS);
  localparam logic [2:0] LAST_ROUND = 3'(ROUNDS);

  if (MAX_CARDS < 2 || MAX_CARDS > 8 || ROUNDS < 1 || ROUNDS > 7 ||
      LIMIT_HALF > 100 || DEALER_STAND > 127) begin : g_param_check
    $error("tenthirty_engine: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEAL_P  = 3'd1,
    PLAYER  = 3'd2,
    DEAL_D  = 3'd3,
    DEALER  = 3'd4,
    COMPARE = 3'd5,
    DONE    = 3'd6
  } state_e;

  state_e     st;
  logic       hit_q, stand_q;
  logic       hit_e, stand_e, accept;
  logic [6:0] card_pts;
  logic [3:0] card_code;
  logic       player_bust, dealer_bust;
  logic [2:0] dealer_verdict;

  // Button edges only matter on tick; stand is checked before hit everywhere.
  assign hit_e     = btn_hit & ~hit_q;
  assign stand_e   = btn_stand & ~stand_q;
  assign accept    = card_req & card_vld & (card_num != 4'd0);
  assign card_pts  = (card_num >= 4'd11) ? 7'd1 : {2'b00, card_num, 1'b0};
  assign card_code = (card_num >= 4'd11) ? 4'd11 : card_num;

  assign player_bust    = player_tot > LIMIT;
  assign dealer_bust    = dealer_tot > LIMIT;
  assign dealer_verdict = (dealer_bust || player_tot > dealer_tot) ? 3'b001 : 3'b010;
  assign state          = st;

  function automatic logic [6:0] add_sat(input logic [6:0] a, input logic [6:0] b);
    logic [7:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7] ? 7'd127 : s[6:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      hit_q      <= 1'b0;
      stand_q    <= 1'b0;
      card_req   <= 1'b0;
      hand_cards <= '0;
      hand_cnt   <= 4'd0;
      player_tot <= 7'd0;
      dealer_tot <= 7'd0;
      turn       <= 1'b0;
      round_no   <= 3'd0;
      led        <= 3'd0;
    end else begin
      if (tick) begin
        hit_q   <= btn_hit;
        stand_q <= btn_stand;
      end
      case (st)
        IDLE: if (tick && hit_e) begin
          st         <= DEAL_P;
          card_req   <= 1'b1;
          round_no   <= (round_no < LAST_ROUND) ? round_no + 3'd1 : round_no;
          player_tot <= 7'd0;
          dealer_tot <= 7'd0;
          hand_cards <= '0;
          hand_cnt   <= 4'd0;
          led        <= 3'd0;
          turn       <= 1'b0;
        end
        // Card intake runs every clock, independent of tick.
        DEAL_P, DEAL_D: if (accept) begin
          for (int unsigned i = 0; i < MAX_CARDS; i++)
            if (hand_cnt == 4'(i)) hand_cards[4*i +: 4] <= card_code;
          hand_cnt <= hand_cnt + 4'd1;
          card_req <= 1'b0;
          if (st == DEAL_P) begin
            player_tot <= add_sat(player_tot, card_pts);
            st         <= PLAYER;
          end else begin
            dealer_tot <= add_sat(dealer_tot, card_pts);
            st         <= DEALER;
          end
        end
        PLAYER: if (tick) begin
          if (player_bust) begin
            st  <= COMPARE;
            led <= 3'b010;
          end else if (stand_e || hand_cnt == MAXC) begin
            st         <= DEAL_D;
            card_req   <= 1'b1;
            hand_cards <= '0;
            hand_cnt   <= 4'd0;
            turn       <= 1'b1;
          end else if (hit_e) begin
            st       <= DEAL_P;
            card_req <= 1'b1;
          end
        end
        DEALER: if (tick) begin
`ifdef AUTO_DEALER_EN
          if (dealer_tot < 7'(DEALER_STAND) && hand_cnt < MAXC) begin
            st       <= DEAL_D;
            card_req <= 1'b1;
          end else begin
            st  <= COMPARE;
            led <= dealer_verdict;
          end
`else
          if (dealer_bust || stand_e || hand_cnt == MAXC) begin
            st  <= COMPARE;
            led <= dealer_verdict;
          end else if (hit_e) begin
            st       <= DEAL_D;
            card_req <= 1'b1;
          end
`endif
        end
        COMPARE: if (tick && stand_e) begin
          if (round_no == LAST_ROUND) begin
            st  <= DONE;
            led <= 3'b100;
          end else begin
            st  <= IDLE;
            led <= 3'b000;
          end
        end
        DONE: st <= DONE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tenthirty_engine.sv
// Randomized bench for tenthirty_engine: plays whole games against a card-list scoring model.
module tb_tenthirty_engine;
  localparam int MAX_CARDS    = 5;
  localparam int ROUNDS       = 4;
  localparam int LIMIT_HALF   = 21;
  localparam int DEALER_STAND = 14;
  localparam int HAND_W       = 4 * MAX_CARDS;

  logic              clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic              btn_hit = 1'b0, btn_stand = 1'b0, card_vld = 1'b0;
  logic [3:0]        card_num = 4'd0;
  logic              card_req, turn;
  logic [HAND_W-1:0] hand_cards;
  logic [3:0]        hand_cnt;
  logic [6:0]        player_tot, dealer_tot;
  logic [2:0]        round_no, state, led;

  int n_vec = 0, n_err = 0;
  int pc[$], dc[$], ps[$];

  always #5 clk = ~clk;

  tenthirty_engine dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_hit(btn_hit), .btn_stand(btn_stand),
    .card_req(card_req), .card_vld(card_vld), .card_num(card_num),
    .hand_cards(hand_cards), .hand_cnt(hand_cnt), .player_tot(player_tot),
    .dealer_tot(dealer_tot), .turn(turn), .round_no(round_no), .state(state), .led(led)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int half_pts(input int n);
    return (n >= 11) ? 1 : 2 * n;
  endfunction

  function automatic int hsum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += half_pts(q[i]);
    return s;
  endfunction

  function automatic logic [HAND_W-1:0] hpack(input int q[$]);
    logic [HAND_W-1:0] v = '0;
    foreach (q[i]) v[4*i +: 4] = (q[i] >= 11) ? 4'd11 : 4'(q[i]);
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  // Buttons are held a couple of clocks without tick first: nothing may move.
  task automatic press(input logic h, input logic s);
    logic [2:0] s0;
    s0 = state;
    btn_hit = h;
    btn_stand = s;
    cyc();
    cyc();
    check("no_tick_hold", 32'(state), 32'(s0));
    tick_pulse();
  endtask

  task automatic release_btns();
    btn_hit = 1'b0;
    btn_stand = 1'b0;
    tick_pulse();
  endtask

  task automatic deal(input bit to_player);
    int budget = 0;
    int c;
    while (!card_req && budget < 50) begin
      cyc();
      budget++;
    end
    check("card_req_wait", 32'(card_req), 1);
    if ($urandom_range(0, 5) == 0) begin
      card_num = 4'd0;
      card_vld = 1'b1;
      cyc();
      cyc();
      check("illegal_req_held", 32'(card_req), 1);
      check("illegal_state", 32'(state), to_player ? 1 : 3);
      check("illegal_cnt", 32'(hand_cnt), to_player ? pc.size() : dc.size());
    end
    if (to_player && ps.size() > 0) c = ps.pop_front();
    else c = $urandom_range(1, 15);
    card_num = 4'(c);
    card_vld = 1'b1;
    cyc();
    card_vld = 1'b0;
    card_num = 4'd0;
    if (to_player) begin
      pc.push_back(c);
      check("player_tot", 32'(player_tot), hsum(pc));
      check("player_state", 32'(state), 2);
      check("player_cnt", 32'(hand_cnt), pc.size());
      check("player_hand", 32'(hand_cards), 32'(hpack(pc)));
    end else begin
      dc.push_back(c);
      check("dealer_tot", 32'(dealer_tot), hsum(dc));
      check("dealer_state", 32'(state), 4);
      check("dealer_cnt", 32'(hand_cnt), dc.size());
      check("dealer_hand", 32'(hand_cards), 32'(hpack(dc)));
    end
    check("req_dropped", 32'(card_req), 0);
  endtask

  task automatic play_round(input int rnd);
    int r, psum, dsum;
    bit p_done, bust, d_done;
    logic [2:0] exp_led;
    pc.delete();
    dc.delete();
    check("idle_state", 32'(state), 0);
    press(1'b1, 1'b0);
    check("start_state", 32'(state), 1);
    check("round_no", 32'(round_no), rnd);
    check("led_clear", 32'(led), 0);
    check("start_turn", 32'(turn), 0);
    release_btns();
    bust = 0;
    p_done = 0;
    while (!p_done) begin
      deal(1'b1);
      psum = hsum(pc);
      if (psum > LIMIT_HALF) begin
        tick_pulse();
        check("bust_state", 32'(state), 5);
        check("bust_no_req", 32'(card_req), 0);
        check("bust_turn", 32'(turn), 0);
        bust = 1;
        p_done = 1;
      end else if (pc.size() == MAX_CARDS) begin
        tick_pulse();
        check("limit_state", 32'(state), 3);
        check("limit_turn", 32'(turn), 1);
        check("limit_cnt", 32'(hand_cnt), 0);
        p_done = 1;
      end else begin
        r = $urandom_range(0, 9);
        if (ps.size() > 0 || (psum <= 12 && r > 1 && r < 8)) begin
          press(1'b1, 1'b0);
          check("hit_state", 32'(state), 1);
        end else begin
          press(r == 0, 1'b1);
          check("stand_state", 32'(state), 3);
          check("stand_turn", 32'(turn), 1);
          check("stand_hand", 32'(hand_cards), 0);
          p_done = 1;
        end
        release_btns();
      end
    end
    if (!bust) begin
      d_done = 0;
      while (!d_done) begin
        deal(1'b0);
        dsum = hsum(dc);
`ifdef AUTO_DEALER_EN
        tick_pulse();
        if (dsum < DEALER_STAND && dc.size() < MAX_CARDS) check("auto_draw", 32'(state), 3);
        else begin
          check("auto_stop", 32'(state), 5);
          d_done = 1;
        end
`else
        if (dsum > LIMIT_HALF || dc.size() == MAX_CARDS) begin
          tick_pulse();
          check("dealer_end", 32'(state), 5);
          d_done = 1;
        end else begin
          r = $urandom_range(0, 9);
          if (dsum <= 12 && r < 8) begin
            press(1'b1, 1'b0);
            check("dealer_hit", 32'(state), 3);
          end else begin
            press(1'b0, 1'b1);
            check("dealer_stand", 32'(state), 5);
            d_done = 1;
          end
          release_btns();
        end
`endif
      end
    end
    psum = hsum(pc);
    dsum = hsum(dc);
    if (psum > LIMIT_HALF) exp_led = 3'b010;
    else if (dsum > LIMIT_HALF || psum > dsum) exp_led = 3'b001;
    else exp_led = 3'b010;
    check("cmp_state", 32'(state), 5);
    check("cmp_led", 32'(led), 32'(exp_led));
    check("cmp_ptot", 32'(player_tot), psum);
    check("cmp_dtot", 32'(dealer_tot), dsum);
    press(1'b0, 1'b1);
    check("next_state", 32'(state), (rnd == ROUNDS) ? 6 : 0);
    check("next_led", 32'(led), (rnd == ROUNDS) ? 4 : 0);
    release_btns();
  endtask

  initial begin
    cyc();
    cyc();
    check("rst_state", 32'(state), 0);
    check("rst_req", 32'(card_req), 0);
    check("rst_round", 32'(round_no), 0);
    check("rst_led", 32'(led), 0);
    check("rst_hand", 32'(hand_cards), 0);
    rst_n = 1'b1;
    cyc();
    check("post_rst_state", 32'(state), 0);

    // Reset while a card is being requested and offered.
    press(1'b1, 1'b0);
    check("t1_state", 32'(state), 1);
    check("t1_req", 32'(card_req), 1);
    release_btns();
    card_num = 4'd7;
    card_vld = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t1_req_async", 32'(card_req), 0);
    check("t1_state_async", 32'(state), 0);
    check("t1_round_async", 32'(round_no), 0);
    cyc();
    cyc();
    card_vld = 1'b0;
    card_num = 4'd0;
    rst_n = 1'b1;
    cyc();
    check("t1_cnt", 32'(hand_cnt), 0);
    check("t1_ptot", 32'(player_tot), 0);
    check("t1_state_after", 32'(state), 0);

    for (int g = 0; g < 2; g++) begin
      for (int rnd = 1; rnd <= ROUNDS; rnd++) begin
        ps.delete();
        if (g == 0 && rnd == 1) ps = '{11, 13, 15, 12, 14};
        if (g == 0 && rnd == 2) ps = '{10, 1};
        if (g == 0 && rnd == 3) ps = '{10, 11};
        play_round(rnd);
      end
      press(1'b1, 1'b1);
      check("done_sticky", 32'(state), 6);
      check("done_led", 32'(led), 4);
      check("done_round", 32'(round_no), ROUNDS);
      release_btns();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      check("game_rst_round", 32'(round_no), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
